// File: rtl/mc_main_control.sv
// mc_main_control -- multi-cycle main control FSM for the MIPS-lite datapath.
//
// Sequences each instruction through fetch, decode, execute, memory and
// write-back. It drives every datapath enable and mux select, and produces the
// 2-bit aluop class that the ALU-control decoder resolves together with func.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset (forces RESET, outputs 0)
//   opcode     in   IR[31:26], sampled in DECODE (and MEM_ADDR for LW/SW)
//   zero       in   ALU zero flag, gates pc_write in BRANCH only
//   mem_ready  in   memory-done strobe, used only with MC_CTRL_MEM_WAIT_EN
//   pc_write   out  PC load enable
//   iord       out  memory address select (0 = PC, 1 = ALUOut)
//   mem_read   out  memory read strobe
//   mem_write  out  memory write strobe
//   ir_write   out  IR load enable
//   reg_dst    out  write register select (0 = rt, 1 = rd)
//   mem_to_reg out  write-back source (0 = ALUOut, 1 = MDR)
//   reg_write  out  register-file write enable
//   alu_src_a  out  ALU A select (0 = PC, 1 = A)
//   alu_src_b  out  ALU B select (00 B, 01 4, 10 ext(imm), 11 sext(imm)<<2)
//   ext_zero   out  immediate extension (1 = zero, 0 = sign)
//   pc_source  out  PC source (00 ALU, 01 ALUOut, 10 jump target)
//   aluop      out  ALU class (00 ADD, 01 SUB, 10 R_TYPE, 11 ORI)
//   illegal    out  one-cycle pulse on an unrecognised opcode
//
// Configuration macro:
//   MC_CTRL_MEM_WAIT_EN  FETCH, MEM_RD and MEM_WR hold until mem_ready = 1.
module mc_main_control #(
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic            ext_zero,
  output logic [1:0]      pc_source,
  output logic [1:0]      aluop,
  output logic            illegal
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_SUB    = 2'b01;
  localparam logic [1:0] ALU_OP_R_TYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ORI    = 2'b11;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_R_EXEC,
    S_R_WB,
    S_ORI_EXEC,
    S_ORI_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_ILLEGAL
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  logic   w_mem_ok;
  logic   w_unused;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign w_mem_ok = mem_ready;
  assign w_unused = 1'b0;
`else
  assign w_mem_ok = 1'b1;
  assign w_unused = mem_ready;
`endif

  // Control word for each state; BRANCH's pc_write is added outside because
  // it follows zero combinationally.
  function automatic ctrl_t f_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    c.aluop = ALU_OP_ADD;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.aluop     = ALU_OP_R_TYPE;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_ORI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.ext_zero  = 1'b1;
        c.aluop     = ALU_OP_ORI;
      end
      S_ORI_WB:   c.reg_write = 1'b1;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.aluop     = ALU_OP_SUB;
        c.pc_source = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ILLEGAL:  c.illegal = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:    w_next = S_FETCH;
      S_FETCH:    w_next = w_mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_RTYPE)                     w_next = S_R_EXEC;
        else if (opcode == OP_LW || opcode == OP_SW) w_next = S_MEM_ADDR;
        else if (opcode == OP_BEQ)                  w_next = S_BRANCH;
        else if (opcode == OP_J)                    w_next = S_JUMP;
        else if (opcode == OP_ORI)                  w_next = S_ORI_EXEC;
        else                                        w_next = S_ILLEGAL;
      end
      S_R_EXEC:   w_next = S_R_WB;
      S_ORI_EXEC: w_next = S_ORI_WB;
      S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next = w_mem_ok ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   w_next = w_mem_ok ? S_FETCH : S_MEM_WR;
      default:    w_next = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESET;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= f_ctrl(w_next);
    end
  end

  // While FETCH waits on memory, IR and PC loads fire only in the ready cycle.
  assign pc_write   = (r_ctrl.pc_write & ((r_state != S_FETCH) | w_mem_ok))
                    | ((r_state == S_BRANCH) & zero);
  assign ir_write   = r_ctrl.ir_write & w_mem_ok;
  assign iord       = r_ctrl.iord;
  assign mem_read   = r_ctrl.mem_read;
  assign mem_write  = r_ctrl.mem_write;
  assign reg_dst    = r_ctrl.reg_dst;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign reg_write  = r_ctrl.reg_write;
  assign alu_src_a  = r_ctrl.alu_src_a;
  assign alu_src_b  = r_ctrl.alu_src_b;
  assign ext_zero   = r_ctrl.ext_zero;
  assign pc_source  = r_ctrl.pc_source;
  assign aluop      = r_ctrl.aluop;
  assign illegal    = r_ctrl.illegal;

endmodule

// File: tb/tb_mc_main_control.sv
// Testbench for mc_main_control: directed scenarios plus randomized
// instruction streams, checked against an instruction-level model giving the
// expected control word for each cycle of each instruction.
module tb_mc_main_control;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_ORI = 6'b001101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, ext_zero, illegal;
  logic [1:0] alu_src_b, pc_source, aluop;
  logic [16:0] obs;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  mc_main_control #(.OP_W(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .pc_source(pc_source), .aluop(aluop), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, ext_zero, pc_source, aluop, illegal};

  function automatic int unsigned instr_len(input logic [5:0] op);
    case (op)
      OP_R, OP_ORI, OP_SW: return 4;
      OP_LW:               return 5;
      default:             return 3;
    endcase
  endfunction

  // Expected control word for cycle idx (0 = FETCH) of instruction op.
  function automatic logic [16:0] exp_ctrl(input logic [5:0] op, input int unsigned idx,
                                           input logic z);
    logic pcw, io, mr, mw, irw, rd, m2r, rw, asa, ez, ill;
    logic [1:0] asb, pcs, aop;
    {pcw, io, mr, mw, irw, rd, m2r, rw, asa, ez, ill} = '0;
    {asb, pcs, aop} = '0;
    if (idx == 0) begin
      pcw = 1'b1; mr = 1'b1; irw = 1'b1; asb = 2'b01;
    end else if (idx == 1) begin
      asb = 2'b11;
    end else begin
      case (op)
        OP_R:   if (idx == 2) begin asa = 1'b1; aop = 2'b10; end
                else begin rw = 1'b1; rd = 1'b1; end
        OP_ORI: if (idx == 2) begin asa = 1'b1; asb = 2'b10; ez = 1'b1; aop = 2'b11; end
                else rw = 1'b1;
        OP_LW:  if (idx == 2) begin asa = 1'b1; asb = 2'b10; end
                else if (idx == 3) begin mr = 1'b1; io = 1'b1; end
                else begin rw = 1'b1; m2r = 1'b1; end
        OP_SW:  if (idx == 2) begin asa = 1'b1; asb = 2'b10; end
                else begin mw = 1'b1; io = 1'b1; end
        OP_BEQ: begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; pcw = z; end
        OP_J:   begin pcw = 1'b1; pcs = 2'b10; end
        default: ill = 1'b1;
      endcase
    end
    return {pcw, io, mr, mw, irw, rd, m2r, rw, asa, asb, ez, pcs, aop, ill};
  endfunction

  // Runs one instruction from cycle first_idx; the next edge must enter that cycle.
  // opcode is scrambled in every cycle where the FSM must not look at it.
  task automatic run_instr(input logic [5:0] op, input logic zv, input int unsigned first_idx);
    int unsigned len;
    logic [16:0] want;
    len = instr_len(op);
    for (int unsigned i = first_idx; i < len; i++) begin
      @(posedge clk); #1;
      opcode = (i == 1 || (i == 2 && (op == OP_LW || op == OP_SW))) ? op : 6'($urandom);
      zero   = (i == 2 && op == OP_BEQ) ? zv : 1'($urandom);
`ifdef MC_CTRL_MEM_WAIT_EN
      mem_ready = 1'b1;
`else
      mem_ready = 1'($urandom);
`endif
      #1;
      want = exp_ctrl(op, i, zero);
      n_vec++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL instr op=%b cycle=%0d got=%b want=%b", op, i, obs, want);
      end
    end
  endtask

  task automatic test_reset();
    logic [16:0] want;
    rst = 1'b1; mem_ready = 1'b1; #1;
    n_vec++;
    if (obs !== '0) begin n_err++; $display("FAIL reset_hold got=%b want=0", obs); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    want = exp_ctrl(OP_R, 0, 1'b0);
    n_vec++;
    if (obs !== want) begin n_err++; $display("FAIL reset_fetch got=%b want=%b", obs, want); end
    #2 rst = 1'b1; #1;
    n_vec++;
    if (obs !== '0) begin n_err++; $display("FAIL reset_async got=%b want=0", obs); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    run_instr(OP_R, 1'b0, 0);
    run_instr(OP_R, 1'b1, 0);
  endtask

  task automatic test_lw_sw();
    run_instr(OP_LW, 1'b0, 0);
    run_instr(OP_SW, 1'b0, 0);
    run_instr(OP_LW, 1'b1, 0);
  endtask

  task automatic test_branch_jump();
    run_instr(OP_BEQ, 1'b1, 0);
    run_instr(OP_BEQ, 1'b0, 0);
    run_instr(OP_J, 1'b0, 0);
  endtask

  task automatic test_ori_illegal();
    run_instr(OP_ORI, 1'b0, 0);
    run_instr(6'b111111, 1'b0, 0);
    run_instr(6'b100000, 1'b1, 0);
  endtask

  // Abort an LW in MEM_RD: outputs drop at once and no write-back follows.
  task automatic test_reset_midinstr();
    logic [16:0] want;
    run_instr(OP_R, 1'b0, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      opcode = OP_LW; mem_ready = 1'b1; #1;
      want = exp_ctrl(OP_LW, i, 1'b0);
      n_vec++;
      if (obs !== want) begin n_err++; $display("FAIL abort_pre cycle=%0d got=%b want=%b", i, obs, want); end
    end
    #2 rst = 1'b1; #1;
    n_vec++;
    if (obs !== '0) begin n_err++; $display("FAIL abort_rst got=%b want=0", obs); end
    @(posedge clk); #1;
    n_vec++;
    if (obs !== '0) begin n_err++; $display("FAIL abort_hold got=%b want=0", obs); end
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef MC_CTRL_MEM_WAIT_EN
  task automatic test_mem_wait();
    logic [16:0] want;
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mem_ready = 1'b0; #1;
      want = exp_ctrl(OP_R, 0, 1'b0) & ~17'b1000_1000_0000_0000_0;
      n_vec++;
      if (obs !== want) begin n_err++; $display("FAIL fetch_wait cycle=%0d got=%b want=%b", i, obs, want); end
    end
    @(posedge clk); #1;
    mem_ready = 1'b1; #1;
    want = exp_ctrl(OP_R, 0, 1'b0);
    n_vec++;
    if (obs !== want) begin n_err++; $display("FAIL fetch_ready got=%b want=%b", obs, want); end
    run_instr(OP_R, 1'b0, 1);
  endtask
`endif

  task automatic test_random();
    logic [5:0] ops [6];
    logic [5:0] op;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        op = 6'($urandom);
        while (op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
               op == OP_J || op == OP_ORI)
          op = 6'($urandom);
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, 1'($urandom), 0);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_sw();
    test_branch_jump();
    test_ori_illegal();
    test_reset_midinstr();
`ifdef MC_CTRL_MEM_WAIT_EN
    test_mem_wait();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
